bram_pattern_tester: RTL and testbench
======================================

Name: bram_pattern_tester

Overview:
- Parametrised successor to the fixed-pattern BRAM self-test block.
- Fills an internal simple-dual-port RAM (inferred, 1 write port, 1 read port, 1-cycle registered read) with a selectable data pattern.
- On request, reads the whole RAM back and counts mismatches, capturing the first failing address.
- Handshakes with the downstream result sender via start/send_end.

Parameters:
DATA_W, 16, RAM word width (≥2)
ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W
TEST_DATA, 16'hAA55, base pattern, truncated/zero-extended to DATA_W
ERR_W, 32, error counter width
INJECT_ADDR, 0, fault-injection address (optional feature only)

Ports:
BRAM_sys_clk  in  1  clock
BRAM_rst_n  in  1  asynchronous, active-low reset
BRAM_start  in  1  level; sampled only in R_IDLE
send_end  in  1  level; result consumed, sampled only in R_END
mode  in  2  pattern select: 0 const, 1 address, 2 checkerboard, 3 walking-one
BRAM_busy  out  1  high in W_IDLE/WRITE/READ
BRAM_end  out  1  result valid, high while in R_END
BRAM_error  out  ERR_W  mismatch count of last read pass, saturating
first_err_addr  out  ADDR_W  address of first mismatch of last pass
first_err_valid  out  1  at least one mismatch in last pass

Behaviour:
- Reset values: all outputs 0; state W_IDLE; latched mode 0; pending-start 0.
- Clock and reset: BRAM_sys_clk, with BRAM_rst_n as the asynchronous, active-low reset.
- Pattern p(a), for address a:
  - mode 0: TEST_DATA.
  - mode 1: a, zero-extended or truncated to DATA_W.
  - mode 2: TEST_DATA if a[0]==0, else ~TEST_DATA.
  - mode 3: 1 << (a mod DATA_W).
- The pattern uses the latched mode, not the live input.
- W_IDLE (1 cycle):
  - Latch mode.
  - Write address = 0.
  - Go to WRITE.
- WRITE (DEPTH cycles):
  - Writes p(a) to a = 0..DEPTH-1, one per cycle.
  - On the final word, go to READ if pending-start is set (clear it); otherwise go to R_IDLE.
- R_IDLE:
  - Accept BRAM_start=1: clear BRAM_error, first_err_valid and first_err_addr.
  - If mode == latched mode, go to READ.
  - Otherwise set pending-start and go to W_IDLE (rewrite with the new pattern, then read automatically).
- READ (DEPTH+1 cycles):
  - Cycles 0..DEPTH-1 issue read addresses 0..DEPTH-1. All addresses are checked, including 0.
  - Data returns 1 cycle later and is compared against p(addr delayed 1 cycle) under a valid pipe bit.
  - On mismatch: BRAM_error += 1, saturating at all-ones.
  - On the first mismatch of the pass: first_err_addr = that address, first_err_valid = 1.
  - The last compare occurs in cycle DEPTH, then go to R_END.
- R_END:
  - BRAM_end=1; outputs held stable.
  - On send_end=1: go to W_IDLE if first_err_valid (full rewrite, no auto-read); otherwise go to R_IDLE.
- BRAM_end and BRAM_busy are registered:
  - They assert on the edge that enters the qualifying state.
  - They deassert on the edge that leaves it.
- Boundary conditions:
  - BRAM_start outside R_IDLE: ignored, not queued. It is acted on if still high when R_IDLE is reached.
  - send_end outside R_END: ignored.
  - BRAM_start and send_end both high in R_END: send_end is acted on; start is evaluated in R_IDLE next cycle.
  - Reset asserted mid-WRITE/READ: immediate return to W_IDLE and all outputs 0. After release, a full rewrite runs with mode 0 latched at W_IDLE.
  - RAM contents are not reset.
  - Write and read addresses never collide in the same cycle (phases are exclusive); no read-during-write behaviour is required.
- Illegal state encoding: go to W_IDLE and clear all outputs.

Optional Feature:
- Macro: BRAM_TEST_FAULT_INJECT_EN.
- When defined:
  - Adds input port inject (1 bit), sampled at W_IDLE.
  - If latched high, the word written at INJECT_ADDR is p(INJECT_ADDR) with bit 0 inverted, so every subsequent read pass reports exactly 1 error at INJECT_ADDR.
- When undefined:
  - No inject port.
  - Writes are always p(a).

Test Plan:
1. DATA_W=16, ADDR_W=4, mode=0; release reset; after 17 cycles pulse BRAM_start -> READ 17 cycles, BRAM_end=1, BRAM_error=0, first_err_valid=0.
2. mode=2 set in R_IDLE then BRAM_start -> rewrite (17 cycles), auto-read without a second start, BRAM_error=0, RAM[1]==16'h55AA.
3. Macro defined, INJECT_ADDR=5, inject=1, mode=1 -> BRAM_error=1, first_err_addr=5, first_err_valid=1; send_end -> W_IDLE rewrite, then R_IDLE.
4. mode=3, DATA_W=8, ADDR_W=4 -> RAM[9]==8'h02, BRAM_error=0 on read.
5. Assert BRAM_rst_n=0 at READ cycle 7 -> all outputs 0 the same cycle; after release BRAM_busy=1 and a full write precedes any read.
6. Hold BRAM_start=1 continuously with no errors -> BRAM_end stays high until send_end; after send_end, R_IDLE for 1 cycle, then a new READ with BRAM_error cleared to 0.

Source files
------------

// File: rtl/bram_pattern_tester.sv
// ---------------------------------------------------------------------------
// bram_pattern_tester
//   BRAM self-test engine. It fills an inferred simple-dual-port RAM with a
//   selectable data pattern, then on request reads the whole RAM back and
//   counts mismatches against the same pattern. It also captures the first
//   failing address. A downstream sender consumes the result with send_end.
//
//   Optional feature macro: BRAM_TEST_FAULT_INJECT_EN
//     When defined, this adds an 'inject' input. If inject is latched high at
//     W_IDLE, the word written at INJECT_ADDR gets bit 0 inverted, so every
//     later read pass reports exactly one error at that address.
//
// Parameters
//   DATA_W      RAM word width (>= 2)
//   ADDR_W      RAM address width, DEPTH = 2**ADDR_W
//   TEST_DATA   base pattern, truncated / zero-extended to DATA_W
//   ERR_W       error counter width (saturating)
//   INJECT_ADDR fault-injection address (optional feature only)
//
// Ports
//   BRAM_sys_clk     in   clock
//   BRAM_rst_n       in   asynchronous active-low reset
//   BRAM_start       in   level, request a read pass (acted on in R_IDLE)
//   send_end         in   level, result consumed (acted on in R_END)
//   mode       [1:0] in   0 const, 1 address, 2 checkerboard, 3 walking-one
//   inject           in   (optional) corrupt the word at INJECT_ADDR
//   BRAM_busy        out  high in W_IDLE / WRITE / READ
//   BRAM_end         out  result valid, high in R_END
//   BRAM_error [ERR_W] out  mismatch count of last pass, saturating
//   first_err_addr   out  address of first mismatch of last pass
//   first_err_valid  out  at least one mismatch in last pass
// ---------------------------------------------------------------------------
module bram_pattern_tester #(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 10,
  parameter logic [63:0] TEST_DATA   = 64'hAA55,
  parameter int          ERR_W       = 32,
  parameter int          INJECT_ADDR = 0
) (
  input  logic              BRAM_sys_clk,
  input  logic              BRAM_rst_n,
  input  logic              BRAM_start,
  input  logic              send_end,
  input  logic [1:0]        mode,
`ifdef BRAM_TEST_FAULT_INJECT_EN
  input  logic              inject,
`endif
  output logic              BRAM_busy,
  output logic              BRAM_end,
  output logic [ERR_W-1:0]  BRAM_error,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] TD = DATA_W'(TEST_DATA);

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    WRITE  = 3'd1,
    R_IDLE = 3'd2,
    READ   = 3'd3,
    R_END  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        mode_q;
  logic              pend_q, pend_nxt;
  logic              start_acc;
  logic              illegal;

  logic [ADDR_W-1:0] wr_addr;
  logic              wr_last;
  logic              we;
  logic [DATA_W-1:0] wr_data;

  // rd_cnt runs 0..DEPTH. The MSB marks the extra drain cycle, in which no
  // read is issued and only the last compare happens.
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_issue;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              cmp_vld;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              mismatch;

  // Pattern generator. It is shared by the write path and the compare path,
  // so both always see the same latched mode.
  function automatic logic [DATA_W-1:0] pat(input logic [1:0]        m,
                                            input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] one;
    one = DATA_W'(1);
    case (m)
      2'd0:    pat = TD;
      2'd1:    pat = DATA_W'(a);
      2'd2:    pat = a[0] ? ~TD : TD;
      default: pat = one << (32'(a) % DATA_W);
    endcase
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge BRAM_sys_clk or negedge BRAM_rst_n) begin
    if (!BRAM_rst_n) begin
      state  <= W_IDLE;
      pend_q <= 1'b0;
      mode_q <= 2'd0;
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
      if (state == W_IDLE) mode_q <= mode;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_q;
    start_acc = 1'b0;
    illegal   = 1'b0;
    case (state)
      W_IDLE: state_nxt = WRITE;
      WRITE: begin
        if (wr_last) begin
          if (pend_q) begin
            state_nxt = READ;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = R_IDLE;
          end
        end
      end
      R_IDLE: begin
        if (BRAM_start) begin
          start_acc = 1'b1;
          // A new mode needs a rewrite first. The pending flag turns the
          // end of that rewrite straight into a read pass.
          if (mode == mode_q) begin
            state_nxt = READ;
          end else begin
            pend_nxt  = 1'b1;
            state_nxt = W_IDLE;
          end
        end
      end
      READ: if (rd_done) state_nxt = R_END;
      // A failed pass rewrites the RAM, so the next pass starts from
      // known-good contents. That rewrite does not start a read by itself.
      R_END: if (send_end) state_nxt = first_err_valid ? W_IDLE : R_IDLE;
      default: begin
        state_nxt = W_IDLE;
        pend_nxt  = 1'b0;
        illegal   = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- write
  always_ff @(posedge BRAM_sys_clk or negedge BRAM_rst_n) begin
    if (!BRAM_rst_n)          wr_addr <= '0;
    else if (state == WRITE)  wr_addr <= wr_addr + 1'b1;
    else                      wr_addr <= '0;
  end

  assign we      = (state == WRITE);
  assign wr_last = we && (wr_addr == '1);

`ifdef BRAM_TEST_FAULT_INJECT_EN
  logic inj_q;

  always_ff @(posedge BRAM_sys_clk or negedge BRAM_rst_n) begin
    if (!BRAM_rst_n)           inj_q <= 1'b0;
    else if (state == W_IDLE)  inj_q <= inject;
  end

  assign wr_data = pat(mode_q, wr_addr) ^
                   ((inj_q && (wr_addr == ADDR_W'(INJECT_ADDR))) ? DATA_W'(1) : '0);
`else
  logic unused_inject_addr;
  assign unused_inject_addr = (INJECT_ADDR != 0);
  assign wr_data = pat(mode_q, wr_addr);
`endif

  // ---------------------------------------------------------------- read
  always_ff @(posedge BRAM_sys_clk or negedge BRAM_rst_n) begin
    if (!BRAM_rst_n)         rd_cnt <= '0;
    else if (state == READ)  rd_cnt <= rd_cnt + 1'b1;
    else                     rd_cnt <= '0;
  end

  assign rd_addr  = rd_cnt[ADDR_W-1:0];
  assign rd_issue = (state == READ) && !rd_cnt[ADDR_W];
  assign rd_done  = (state == READ) &&  rd_cnt[ADDR_W];

  // RAM array: it is not reset. The write and read phases never overlap.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge BRAM_sys_clk) begin
    if (we)       mem[wr_addr] <= wr_data;
    if (rd_issue) rd_data      <= mem[rd_addr];
  end

  // The read valid and read address are delayed one cycle, to line up with
  // the registered RAM output.
  always_ff @(posedge BRAM_sys_clk or negedge BRAM_rst_n) begin
    if (!BRAM_rst_n) begin
      cmp_vld   <= 1'b0;
      rd_addr_d <= '0;
    end else begin
      cmp_vld   <= rd_issue;
      rd_addr_d <= rd_addr;
    end
  end

  assign mismatch = cmp_vld && (rd_data != pat(mode_q, rd_addr_d));

  // ---------------------------------------------------------------- outputs
  // busy and end are derived from the next state, so they change on the
  // same edge that enters or leaves the qualifying state.
  always_ff @(posedge BRAM_sys_clk or negedge BRAM_rst_n) begin
    if (!BRAM_rst_n) begin
      BRAM_busy       <= 1'b0;
      BRAM_end        <= 1'b0;
      BRAM_error      <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else if (illegal) begin
      BRAM_busy       <= 1'b0;
      BRAM_end        <= 1'b0;
      BRAM_error      <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else begin
      BRAM_busy <= (state_nxt == W_IDLE) || (state_nxt == WRITE) ||
                   (state_nxt == READ);
      BRAM_end  <= (state_nxt == R_END);
      if (start_acc) begin
        BRAM_error      <= '0;
        first_err_addr  <= '0;
        first_err_valid <= 1'b0;
      end else if (mismatch) begin
        if (BRAM_error != '1) BRAM_error <= BRAM_error + 1'b1;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= rd_addr_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_pattern_tester.sv
// ---------------------------------------------------------------------------
// tb_bram_pattern_tester
//   Directed bench for bram_pattern_tester. u_dut is a 16-bit x 16-word
//   instance that runs the main sequence. u8 is an 8-bit x 16-word instance
//   with a 2-bit error counter, used for walking-one and counter saturation.
//   Inputs are driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bram_pattern_tester;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, send = 1'b0;
  logic [1:0] mode = 2'd0;
  logic start8 = 1'b0, send8 = 1'b0;
  logic [1:0] mode8 = 2'd0;
`ifdef BRAM_TEST_FAULT_INJECT_EN
  logic inject = 1'b0, inject8 = 1'b0;
`endif

  logic        busy, end_, fev;
  logic [31:0] err;
  logic [3:0]  fea;
  logic        busy8, end8, fev8;
  logic [1:0]  err8;
  logic [3:0]  fea8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bram_pattern_tester #(.DATA_W(16), .ADDR_W(4), .TEST_DATA(64'hAA55),
                        .ERR_W(32), .INJECT_ADDR(5)) u_dut (
    .BRAM_sys_clk(clk), .BRAM_rst_n(rst_n), .BRAM_start(start),
    .send_end(send), .mode(mode),
`ifdef BRAM_TEST_FAULT_INJECT_EN
    .inject(inject),
`endif
    .BRAM_busy(busy), .BRAM_end(end_), .BRAM_error(err),
    .first_err_addr(fea), .first_err_valid(fev)
  );

  bram_pattern_tester #(.DATA_W(8), .ADDR_W(4), .TEST_DATA(64'hAA55),
                        .ERR_W(2), .INJECT_ADDR(0)) u8 (
    .BRAM_sys_clk(clk), .BRAM_rst_n(rst_n), .BRAM_start(start8),
    .send_end(send8), .mode(mode8),
`ifdef BRAM_TEST_FAULT_INJECT_EN
    .inject(inject8),
`endif
    .BRAM_busy(busy8), .BRAM_end(end8), .BRAM_error(err8),
    .first_err_addr(fea8), .first_err_valid(fev8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts consecutive falling edges with busy high, starting at the current
  // one. It leaves the bench on the first edge with busy low. -1 means the
  // bound expired.
  task automatic run_busy(input bit sel, output int n);
    n = 0;
    while ((sel ? busy8 : busy) === 1'b1) begin
      n++;
      if (n > 200) begin
        n = -1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_send();
    send = 1'b1; @(negedge clk); send = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_end",  32'(end_), 0);
    chk("rst_err",  err, 0);
    chk("rst_fev",  32'(fev), 0);
    chk("rst_fea",  32'(fea), 0);

    // After release: W_IDLE with busy still 0, then 16 write cycles.
    rst_n = 1'b1;
    @(negedge clk);
    run_busy(0, n);
    chk("init_write_cycles", n, 16);
    chk("init_ridle_end", 32'(end_), 0);

    // Mode 0 read pass.
    pulse_start();
    run_busy(0, n);
    chk("t1_read_cycles", n, 17);
    chk("t1_end", 32'(end_), 1);
    chk("t1_err", err, 0);
    chk("t1_fev", 32'(fev), 0);
    repeat (3) @(negedge clk);
    chk("t1_end_hold", 32'(end_), 1);
    pulse_send();
    chk("t1_send_end", 32'(end_), 0);
    chk("t1_send_busy", 32'(busy), 0);

    // A send_end in R_IDLE is ignored.
    pulse_send();
    @(negedge clk);
    chk("stray_send", 32'({end_, busy}), 0);

    // A mode change forces a rewrite, followed by an automatic read.
    mode = 2'd2;
    pulse_start();
    run_busy(0, n);
    chk("t2_rewrite_read_cycles", n, 34);
    chk("t2_end", 32'(end_), 1);
    chk("t2_err", err, 0);
    chk("t2_ram1", 32'(u_dut.mem[1]), 32'h55AA);
    chk("t2_ram0", 32'(u_dut.mem[0]), 32'hAA55);
    pulse_send();

    // Corrupt addresses 0, 9 and 15 (the first and last addresses).
    u_dut.mem[0]  = '0;
    u_dut.mem[9]  = '0;
    u_dut.mem[15] = '0;
    pulse_start();
    run_busy(0, n);
    chk("err_read_cycles", n, 17);
    chk("err_count", err, 3);
    chk("err_first_addr", 32'(fea), 0);
    chk("err_first_valid", 32'(fev), 1);

    // start and send_end together in R_END: send wins and a rewrite follows.
    // start stays high through the rewrite and is taken once R_IDLE is
    // reached.
    start = 1'b1; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk("both_end", 32'(end_), 0);
    chk("both_busy", 32'(busy), 1);
    chk("both_err_held", err, 3);
    run_busy(0, n);
    chk("both_rewrite_cycles", n, 17);
    chk("both_ridle_err", err, 3);
    @(negedge clk);
    chk("hold_busy", 32'(busy), 1);
    chk("hold_err_clr", err, 0);
    chk("hold_fev_clr", 32'(fev), 0);
    run_busy(0, n);
    chk("hold_read_cycles", n, 17);
    chk("hold_err", err, 0);
    repeat (4) @(negedge clk);
    chk("hold_end_stays", 32'(end_), 1);
    pulse_send();
    chk("hold_ridle", 32'({end_, busy}), 0);
    @(negedge clk);
    chk("hold_reread_busy", 32'(busy), 1);
    start = 1'b0;
    run_busy(0, n);
    chk("hold_reread_cycles", n, 17);
    chk("hold_reread_end", 32'(end_), 1);
    pulse_send();

    // Reset in READ cycle 7, with one error already counted.
    u_dut.mem[2] = '0;
    pulse_start();
    repeat (7) @(negedge clk);
    chk("mid_read_busy", 32'(busy), 1);
    chk("mid_read_err", err, 1);
    chk("mid_read_fea", 32'(fea), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({busy, end_, fev, fea}), 0);
    chk("mid_rst_err", err, 0);
    mode = 2'd0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_busy(0, n);
    chk("post_rst_write_cycles", n, 16);
    pulse_start();
    run_busy(0, n);
    chk("post_rst_read_cycles", n, 17);
    chk("post_rst_err", err, 0);
    pulse_send();

    // Walking-one pattern on the 8-bit instance.
    mode8 = 2'd3;
    start8 = 1'b1; @(negedge clk); start8 = 1'b0;
    run_busy(1, n);
    chk("t4_cycles", n, 34);
    chk("t4_end", 32'(end8), 1);
    chk("t4_err", 32'(err8), 0);
    chk("t4_ram9", 32'(u8.mem[9]), 32'h02);
    chk("t4_ram7", 32'(u8.mem[7]), 32'h80);
    send8 = 1'b1; @(negedge clk); send8 = 1'b0;
    // Four bad words saturate the 2-bit counter at 3.
    u8.mem[1] = '0; u8.mem[3] = '0; u8.mem[5] = '0; u8.mem[7] = '0;
    start8 = 1'b1; @(negedge clk); start8 = 1'b0;
    run_busy(1, n);
    chk("sat_cycles", n, 17);
    chk("sat_err", 32'(err8), 3);
    chk("sat_fea", 32'(fea8), 1);
    chk("sat_fev", 32'(fev8), 1);

`ifdef BRAM_TEST_FAULT_INJECT_EN
    // Injected fault at address 5, with the address pattern.
    inject = 1'b1; mode = 2'd1;
    pulse_start();
    run_busy(0, n);
    chk("inj_cycles", n, 34);
    chk("inj_err", err, 1);
    chk("inj_fea", 32'(fea), 5);
    chk("inj_fev", 32'(fev), 1);
    inject = 1'b0;
    pulse_send();
    run_busy(0, n);
    chk("inj_rewrite_cycles", n, 17);
    chk("inj_ridle", 32'({end_, busy}), 0);
    pulse_start();
    run_busy(0, n);
    chk("inj_clean_err", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
